// File: rtl/dbus_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package dbus_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;
  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;

  localparam int MAXWAIT_DEF = 4;
  localparam int WAITW       = 4;  // holds MAXWAIT up to 15
endpackage

// File: rtl/dbus_arb_if.sv
// Bundle of both master ports and the downstream data bus port.
interface dbus_arb_if #(parameter int ADDRW = 16, parameter int DATAW = 16);
  logic             m0_req, m0_lock, m0_stall, m0_rd_valid;
  logic [ADDRW-1:0] m0_rd_addr, m0_wr_addr;
  logic [DATAW-1:0] m0_wr_data, m0_rd_data;
  logic [1:0]       m0_wr_en;
  logic             m1_req, m1_stall, m1_rd_valid;
  logic [ADDRW-1:0] m1_rd_addr, m1_wr_addr;
  logic [DATAW-1:0] m1_wr_data, m1_rd_data;
  logic [1:0]       m1_wr_en;
  logic [ADDRW-1:0] dread_addr, dwrite_addr;
  logic [DATAW-1:0] dwrite_data, dread_data;
  logic [1:0]       dwrite_en;

  // arbiter view
  modport slave (
    input  m0_req, m0_lock, m0_rd_addr, m0_wr_addr, m0_wr_data, m0_wr_en,
    output m0_stall, m0_rd_data, m0_rd_valid,
    input  m1_req, m1_rd_addr, m1_wr_addr, m1_wr_data, m1_wr_en,
    output m1_stall, m1_rd_data, m1_rd_valid,
    output dread_addr, dwrite_addr, dwrite_data, dwrite_en,
    input  dread_data
  );

  // masters + bus view
  modport master (
    output m0_req, m0_lock, m0_rd_addr, m0_wr_addr, m0_wr_data, m0_wr_en,
    input  m0_stall, m0_rd_data, m0_rd_valid,
    output m1_req, m1_rd_addr, m1_wr_addr, m1_wr_data, m1_wr_en,
    input  m1_stall, m1_rd_data, m1_rd_valid,
    input  dread_addr, dwrite_addr, dwrite_data, dwrite_en,
    output dread_data
  );
endinterface

// File: rtl/dbus_grant.sv
// Combinational priority: lock holds m0, otherwise m0 wins unless m1 has starved MAXWAIT cycles.
module dbus_grant
  import dbus_pkg::*;
#(
  parameter int MAXWAIT = MAXWAIT_DEF
) (
  input  arb_state_t       state,
  input  logic             m0_req,
  input  logic             m0_lock,
  input  logic             m1_req,
  input  logic [WAITW-1:0] wait_cnt,
  output owner_t           grant
);
  logic locked;

  // Dropping m0_lock releases the bus in the same cycle.
  assign locked = (state == ARB_LOCKED) && m0_lock;

  always_comb begin
    grant = OWN_NONE;
    if (locked)                grant = m0_req ? OWN_M0 : OWN_NONE;
    else if (m0_req && m1_req) grant = (wait_cnt == WAITW'(MAXWAIT)) ? OWN_M1 : OWN_M0;
    else if (m0_req)           grant = OWN_M0;
    else if (m1_req)           grant = OWN_M1;
  end
endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data bus arbiter: same-cycle grant, loser stalled, 1-cycle read return routed to issuer.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int MAXWAIT = MAXWAIT_DEF,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 16
) (
  input logic       clk,
  input logic       reset,
  dbus_arb_if.slave bus
);
  arb_state_t       state;
  owner_t           grant, rd_owner_q;
  logic [WAITW-1:0] wait_cnt;
  logic             m0_req, m1_req, sel1;
  logic [ADDRW-1:0] rd_addr, wr_addr;
  logic [DATAW-1:0] wr_data;

  // Requests are ignored while reset is held so stalls and write enables stay quiet.
  assign m0_req = bus.m0_req & ~reset;
  assign m1_req = bus.m1_req & ~reset;

  dbus_grant #(.MAXWAIT(MAXWAIT)) u_grant (
    .state    (state),
    .m0_req   (m0_req),
    .m0_lock  (bus.m0_lock),
    .m1_req   (m1_req),
    .wait_cnt (wait_cnt),
    .grant    (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_OPEN;
      wait_cnt   <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      state <= (bus.m0_lock && (state == ARB_LOCKED || grant == OWN_M0)) ? ARB_LOCKED : ARB_OPEN;
      if (m1_req && grant != OWN_M1)
        wait_cnt <= (wait_cnt == WAITW'(MAXWAIT)) ? wait_cnt : wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      rd_owner_q <= grant;
    end
  end

  // Idle bus follows m0 inputs; only the write enable marks the cycle as empty.
  assign sel1    = (grant == OWN_M1);
  assign rd_addr = sel1 ? bus.m1_rd_addr : bus.m0_rd_addr;
  assign wr_addr = sel1 ? bus.m1_wr_addr : bus.m0_wr_addr;
  assign wr_data = sel1 ? bus.m1_wr_data : bus.m0_wr_data;

  assign bus.dread_addr  = rd_addr;
  assign bus.dwrite_addr = wr_addr;
  assign bus.dwrite_data = wr_data;
  assign bus.dwrite_en   = (grant == OWN_NONE) ? 2'b00 : (sel1 ? bus.m1_wr_en : bus.m0_wr_en);

  assign bus.m0_stall = m0_req && (grant != OWN_M0);
  assign bus.m1_stall = m1_req && (grant != OWN_M1);

  assign bus.m0_rd_data  = bus.dread_data;
  assign bus.m1_rd_data  = bus.dread_data;
  assign bus.m0_rd_valid = (rd_owner_q == OWN_M0);
  assign bus.m1_rd_valid = (rd_owner_q == OWN_M1);
endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: per-cycle reference model plus a read-return scoreboard queue.
module tb_dbus_arbiter;
  import dbus_pkg::*;

  localparam int MW = 4;

  typedef struct {
    owner_t      own;
    logic [15:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dbus_arb_if #(.ADDRW(16), .DATAW(16)) bus ();

  dbus_arbiter #(.MAXWAIT(MW), .ADDRW(16), .DATAW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_chk = 0;
  int          n_err = 0;
  rd_t         sb[$];
  logic        m_lk;
  int          m_wait;
  logic [15:0] last_addr;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5a3c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.m0_req = 0; bus.m0_lock = 0; bus.m0_rd_addr = '0; bus.m0_wr_addr = '0;
    bus.m0_wr_data = '0; bus.m0_wr_en = '0;
    bus.m1_req = 0; bus.m1_rd_addr = '0; bus.m1_wr_addr = '0;
    bus.m1_wr_data = '0; bus.m1_wr_en = '0;
  endtask

  task automatic set_m0(input logic req, input logic lock, input logic [15:0] ra,
                        input logic [15:0] wa, input logic [15:0] wd, input logic [1:0] we);
    bus.m0_req = req; bus.m0_lock = lock; bus.m0_rd_addr = ra;
    bus.m0_wr_addr = wa; bus.m0_wr_data = wd; bus.m0_wr_en = we;
  endtask

  task automatic set_m1(input logic req, input logic [15:0] ra,
                        input logic [15:0] wa, input logic [15:0] wd, input logic [1:0] we);
    bus.m1_req = req; bus.m1_rd_addr = ra;
    bus.m1_wr_addr = wa; bus.m1_wr_data = wd; bus.m1_wr_en = we;
  endtask

  // Entered 1 time unit after a posedge with inputs applied; returns at the same phase next cycle.
  task automatic tick();
    owner_t      g;
    rd_t         e;
    logic [15:0] ea;
    #2;
    if (m_lk && bus.m0_lock)           g = bus.m0_req ? OWN_M0 : OWN_NONE;
    else if (bus.m0_req && bus.m1_req) g = (m_wait == MW) ? OWN_M1 : OWN_M0;
    else if (bus.m0_req)               g = OWN_M0;
    else if (bus.m1_req)               g = OWN_M1;
    else                               g = OWN_NONE;

    ea = (g == OWN_M1) ? bus.m1_rd_addr : bus.m0_rd_addr;
    chk("m0_stall", bus.m0_stall, bus.m0_req && g != OWN_M0);
    chk("m1_stall", bus.m1_stall, bus.m1_req && g != OWN_M1);
    chk("dread_addr", bus.dread_addr, ea);
    chk("dwrite_addr", bus.dwrite_addr, (g == OWN_M1) ? bus.m1_wr_addr : bus.m0_wr_addr);
    chk("dwrite_data", bus.dwrite_data, (g == OWN_M1) ? bus.m1_wr_data : bus.m0_wr_data);
    chk("dwrite_en", bus.dwrite_en,
        (g == OWN_NONE) ? 2'b00 : ((g == OWN_M1) ? bus.m1_wr_en : bus.m0_wr_en));

    if (sb.size() > 0) e = sb.pop_front();
    else               e = '{OWN_NONE, 16'h0};
    chk("m0_rd_valid", bus.m0_rd_valid, e.own == OWN_M0);
    chk("m1_rd_valid", bus.m1_rd_valid, e.own == OWN_M1);
    if (e.own == OWN_M0) chk("m0_rd_data", bus.m0_rd_data, e.data);
    if (e.own == OWN_M1) chk("m1_rd_data", bus.m1_rd_data, e.data);
    sb.push_back('{g, memf(ea)});

    m_lk = bus.m0_lock && (m_lk || g == OWN_M0);
    if (bus.m1_req && g != OWN_M1) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
    else                           m_wait = 0;
    last_addr = bus.dread_addr;
    @(posedge clk);
    #1;
    bus.dread_data = memf(last_addr);
  endtask

  task automatic model_reset();
    sb.delete();
    m_lk = 0;
    m_wait = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    bus.dread_data = '0;
    last_addr = '0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_m0_stall", bus.m0_stall, 1'b0);
    chk("rst_m1_rd_valid", bus.m1_rd_valid, 1'b0);
    chk("rst_dwrite_en", bus.dwrite_en, 2'b00);
    chk("rst_dread_addr", bus.dread_addr, 16'h0);
    @(posedge clk); #1;
    reset = 0;
    tick();

    // m0 alone: address passes through, data returns one cycle later
    set_m0(1, 0, 16'h2010, 16'h0, 16'h0, 2'b00);
    #1;
    chk("t2_dread_addr", bus.dread_addr, 16'h2010);
    chk("t2_m0_stall", bus.m0_stall, 1'b0);
    tick();
    idle_inputs();
    #1;
    chk("t2_m0_rd_valid", bus.m0_rd_valid, 1'b1);
    chk("t2_m0_rd_data", bus.m0_rd_data, memf(16'h2010));
    tick();

    // continuous contention: m1 wins every 5th cycle
    set_m0(1, 0, 16'h1000, 16'h0, 16'h0, 2'b00);
    set_m1(1, 16'h9000, 16'h0, 16'h0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_m1_stall", bus.m1_stall, (i % 5) != 4);
      chk("t3_m0_stall", bus.m0_stall, (i % 5) == 4);
      tick();
      bus.m0_rd_addr = bus.m0_rd_addr + 1;
      bus.m1_rd_addr = bus.m1_rd_addr + 1;
    end
    idle_inputs();
    tick();

    // colliding writes: m0 goes first, m1 follows with its own data
    set_m0(1, 0, 16'h0, 16'h0004, 16'h1234, 2'b11);
    set_m1(1, 16'h0, 16'h8000, 16'hbeef, 2'b01);
    #1;
    chk("t4_dwrite_en", bus.dwrite_en, 2'b11);
    chk("t4_dwrite_addr", bus.dwrite_addr, 16'h0004);
    chk("t4_m1_stall", bus.m1_stall, 1'b1);
    tick();
    set_m0(0, 0, 16'h0, 16'h0, 16'h0, 2'b00);
    #1;
    chk("t4b_dwrite_addr", bus.dwrite_addr, 16'h8000);
    chk("t4b_dwrite_data", bus.dwrite_data, 16'hbeef);
    chk("t4b_dwrite_en", bus.dwrite_en, 2'b01);
    tick();
    idle_inputs();
    tick();

    // lock holds m1 off for 8 cycles (one idle locked cycle); drop releases m1 at once
    set_m1(1, 16'h7700, 16'h0, 16'h0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      set_m0(i != 5, 1, 16'h3000 + 16'(i), 16'h0, 16'h0, 2'b00);
      #1;
      chk("t5_m1_stall", bus.m1_stall, 1'b1);
      tick();
    end
    set_m0(1, 0, 16'h3100, 16'h0, 16'h0, 2'b00);
    #1;
    chk("t5_drop_m1_stall", bus.m1_stall, 1'b0);
    chk("t5_drop_m0_stall", bus.m0_stall, 1'b1);
    tick();
    idle_inputs();
    tick();

    // alternating single-master reads
    set_m0(1, 0, 16'h0a00, 16'h0, 16'h0, 2'b00); tick(); idle_inputs();
    set_m1(1, 16'h0b00, 16'h0, 16'h0, 2'b00);    tick(); idle_inputs();
    set_m0(1, 0, 16'h0c00, 16'h0, 16'h0, 2'b00); tick(); idle_inputs();
    tick();

    // reset mid-cycle with an m1 read in flight
    set_m0(1, 0, 16'h1111, 16'h0, 16'h0, 2'b00);
    set_m1(1, 16'h2222, 16'h0, 16'h0, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset = 1;
    #1;
    chk("t1_m1_rd_valid", bus.m1_rd_valid, 1'b0);
    chk("t1_dwrite_en", bus.dwrite_en, 2'b00);
    chk("t1_m1_stall", bus.m1_stall, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t1_post_m1_stall", bus.m1_stall, i != 4);
      tick();
    end
    idle_inputs();
    tick();

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      set_m0(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) == 0),
             16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
      set_m1(1'($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom),
             16'($urandom), 2'($urandom));
      tick();
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
